// File: rtl/wavetable_gen.sv
// rtl/wavetable_gen.sv - multi-waveform oscillator output stage, one voice per clock, 3-cycle latency
module wavetable_gen #(
  parameter int PHASE_W    = 10,
  parameter int SAMPLE_W   = 16,
  parameter int VOICE_W    = 8,
  parameter int LUT_ADDR_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_enable,
  input  logic                       i_valid,
  input  logic [PHASE_W-1:0]         i_phase,
  input  logic [2:0]                 i_wave_select,
  input  logic [PHASE_W-1:0]         i_pulse_width,
  input  logic [VOICE_W-1:0]         i_voice_index,
  output logic                       o_valid,
  output logic [VOICE_W-1:0]         o_voice_index,
  output logic signed [SAMPLE_W-1:0] o_sample
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam real MAX_R = (2.0 ** (SAMPLE_W - 1)) - 1.0;
  localparam logic signed [SAMPLE_W-1:0] MAX_S = {1'b0, {(SAMPLE_W-1){1'b1}}};
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Quarter-wave table sampled at bin centres so quadrant mirroring needs no end-point fix-up
  logic [SAMPLE_W-2:0] w_rom [LUT_DEPTH];
  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    localparam real ANG = 3.14159265358979 * (k + 0.5) / (2.0 * LUT_DEPTH);
    localparam int  VAL = $rtoi(MAX_R * $sin(ANG) + 0.5);
    assign w_rom[k] = VAL[SAMPLE_W-2:0];
  end

  logic                       r_s0_valid;
  logic [PHASE_W-1:0]         r_s0_phase;
  logic [2:0]                 r_s0_sel;
  logic [PHASE_W-1:0]         r_s0_pw;
  logic [VOICE_W-1:0]         r_s0_voice;

  logic                       r_s1_valid;
  logic [2:0]                 r_s1_sel;
  logic                       r_s1_neg;
  logic [SAMPLE_W-2:0]        r_s1_rom;
  logic signed [SAMPLE_W-1:0] r_s1_wave;
  logic [VOICE_W-1:0]         r_s1_voice;

  logic [15:0]                r_lfsr;

  logic [LUT_ADDR_W-1:0]      w_addr;
  logic [PHASE_W-2:0]         w_tri_t;
  logic [SAMPLE_W-1:0]        w_saw_u;
  logic [SAMPLE_W-1:0]        w_tri_u;
  logic                       w_lfsr_fb;
  logic [15:0]                w_lfsr_next;
  logic                       w_lfsr_step;
  logic signed [SAMPLE_W-1:0] w_wave;
  logic signed [SAMPLE_W-1:0] w_sine_mag;
  logic signed [SAMPLE_W-1:0] w_out;

  // Odd quadrants read the table backwards: N-1-a is simply the bitwise complement of a
  assign w_addr = r_s0_phase[PHASE_W-3 -: LUT_ADDR_W] ^ {LUT_ADDR_W{r_s0_phase[PHASE_W-2]}};

  assign w_tri_t = r_s0_phase[PHASE_W-1] ? ~r_s0_phase[PHASE_W-2:0] : r_s0_phase[PHASE_W-2:0];
  assign w_saw_u = SAMPLE_W'(r_s0_phase) << (SAMPLE_W - PHASE_W);
  assign w_tri_u = SAMPLE_W'(w_tri_t) << (SAMPLE_W - PHASE_W + 1);

  assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_lfsr_next = {w_lfsr_fb, r_lfsr[15:1]};
  assign w_lfsr_step = r_s0_valid && (r_s0_sel == 3'd4);

  // Subtracting 2^(SAMPLE_W-1) from an unsigned ramp is an MSB flip
  always_comb begin
    w_wave = '0;
    case (r_s0_sel)
      3'd1:    w_wave = (r_s0_phase < r_s0_pw) ? MAX_S : -MAX_S;
      3'd2:    w_wave = {~w_saw_u[SAMPLE_W-1], w_saw_u[SAMPLE_W-2:0]};
      3'd3:    w_wave = {~w_tri_u[SAMPLE_W-1], w_tri_u[SAMPLE_W-2:0]};
      3'd4:    w_wave = SAMPLE_W'(w_lfsr_next) << (SAMPLE_W - 16);
      default: w_wave = '0;
    endcase
  end

  assign w_sine_mag = {1'b0, r_s1_rom};
  assign w_out = (r_s1_sel == 3'd0) ? (r_s1_neg ? -w_sine_mag : w_sine_mag) : r_s1_wave;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_s0_valid    <= 1'b0;
      r_s0_phase    <= '0;
      r_s0_sel      <= '0;
      r_s0_pw       <= '0;
      r_s0_voice    <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_sel      <= '0;
      r_s1_neg      <= 1'b0;
      r_s1_rom      <= '0;
      r_s1_wave     <= '0;
      r_s1_voice    <= '0;
      r_lfsr        <= LFSR_SEED;
      o_valid       <= 1'b0;
      o_voice_index <= '0;
      o_sample      <= '0;
    end else if (i_enable) begin
      r_s0_valid    <= i_valid;
      r_s0_phase    <= i_phase;
      r_s0_sel      <= i_wave_select;
      r_s0_pw       <= i_pulse_width;
      r_s0_voice    <= i_voice_index;
      r_s1_valid    <= r_s0_valid;
      r_s1_sel      <= r_s0_sel;
      r_s1_neg      <= r_s0_phase[PHASE_W-1];
      r_s1_rom      <= w_rom[w_addr];
      r_s1_wave     <= w_wave;
      r_s1_voice    <= r_s0_voice;
      if (w_lfsr_step) begin
        r_lfsr <= w_lfsr_next;
      end
      o_valid       <= r_s1_valid;
      o_voice_index <= r_s1_voice;
      o_sample      <= w_out;
    end
  end

endmodule

// File: tb/tb_wavetable_gen.sv
// tb/tb_wavetable_gen.sv - self-checking bench for wavetable_gen against a behavioural waveform model
module tb_wavetable_gen;
  localparam int PW = 10;
  localparam int SW = 16;
  localparam int VW = 8;
  localparam int LA = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          vin = 1'b0;
  logic [PW-1:0] phase = '0;
  logic [2:0]    sel = '0;
  logic [PW-1:0] pw = '0;
  logic [VW-1:0] voice = '0;
  logic          vout;
  logic [VW-1:0] vidx;
  logic [SW-1:0] samp;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;
  logic [15:0] m_lfsr = 16'hACE1;

  typedef struct {int voice; int sample; int stamp;} item_t;
  item_t exp_q[$];
  item_t obs_q[$];

  always #5 clk = ~clk;

  wavetable_gen #(.PHASE_W(PW), .SAMPLE_W(SW), .VOICE_W(VW), .LUT_ADDR_W(LA)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(en), .i_valid(vin), .i_phase(phase),
    .i_wave_select(sel), .i_pulse_width(pw), .i_voice_index(voice),
    .o_valid(vout), .o_voice_index(vidx), .o_sample(samp)
  );

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic b;
    b = s[0] ^ s[2] ^ s[3] ^ s[5];
    return (s >> 1) | (16'(b) << 15);
  endfunction

  function automatic int ref_sample(input int wsel, input int ph, input int pwid, input logic [15:0] nz);
    int q, a, k, v, t;
    case (wsel)
      0: begin
        q = ph / 256;
        a = ph % 256;
        k = (q % 2 == 1) ? 255 - a : a;
        v = $rtoi(32767.0 * $sin(3.14159265358979 * (k + 0.5) / 512.0) + 0.5);
        return (q >= 2) ? -v : v;
      end
      1: return (ph < pwid) ? 32767 : -32767;
      2: return ph * 64 - 32768;
      3: begin
        t = (ph < 512) ? ph : 1023 - ph;
        return t * 128 - 32768;
      end
      4: return int'($signed(nz));
      default: return 0;
    endcase
  endfunction

  // Scoreboard: requests accepted at enabled edges are predicted, outputs are recorded with their edge number
  always @(posedge clk) begin : mon
    item_t it;
    int stamp;
    if (!rst_n) begin
      exp_q.delete();
      m_lfsr = 16'hACE1;
    end else if (en) begin
      edge_cnt++;
      stamp = edge_cnt;
      if (vin) begin
        if (sel == 3'd4) m_lfsr = lfsr_step(m_lfsr);
        it.voice = int'(voice);
        it.sample = ref_sample(int'(sel), int'(phase), int'(pw), m_lfsr);
        it.stamp = stamp + 2;
        exp_q.push_back(it);
      end
      #1;
      if (vout === 1'b1) begin
        it.voice = int'(vidx);
        it.sample = int'($signed(samp));
        it.stamp = stamp;
        obs_q.push_back(it);
      end
    end
  end

  task automatic cyc(input logic v, input logic [2:0] s, input int ph, input int pwid, input int vo, input logic e);
    vin = v; sel = s; phase = PW'(ph); pw = PW'(pwid); voice = VW'(vo); en = e;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 3'd0, 0, 0, 0, 1'b1);
  endtask

  task automatic wait_out(input int n, output bit ok);
    int t;
    t = 0;
    vin = 1'b0; en = 1'b1;
    while (obs_q.size() < n && t < 60) begin
      @(negedge clk);
      t++;
    end
    ok = (obs_q.size() >= n);
  endtask

  task automatic flush();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    bit ok;
    int want;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 3'd4, i * 100, 0, 7, (i % 2 == 0));
      checks++;
      if (vout !== 1'b0 || samp !== '0 || vidx !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d: got valid=%b sample=%0d voice=%0d, want 0/0/0", i, vout, samp, vidx);
      end
    end
    rst_n = 1'b1;
    flush();
    cyc(1'b1, 3'd4, 0, 0, 9, 1'b1);
    wait_out(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reset_first_noise timeout: got %0d outputs, want 1", obs_q.size());
    end else begin
      want = int'($signed(lfsr_step(16'hACE1)));
      checks++;
      if (obs_q[0].sample !== want || obs_q[0].voice !== 9 || obs_q[0].stamp !== exp_q[0].stamp) begin
        errors++;
        $display("FAIL reset_first_noise: got sample=%0d voice=%0d edge=%0d, want %0d/9/%0d",
                 obs_q[0].sample, obs_q[0].voice, obs_q[0].stamp, want, exp_q[0].stamp);
      end
    end
    idle(4);
    flush();
  endtask

  task automatic test_sine();
    bit ok;
    int want_s[4] = '{101, 32767, -101, -32767};
    flush();
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd0, i * 256, 0, i + 1, 1'b1);
    wait_out(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL sine_timeout: got %0d outputs, want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].sample !== want_s[i] || obs_q[i].voice !== i + 1 || obs_q[i].stamp !== exp_q[i].stamp) begin
          errors++;
          $display("FAIL sine_q%0d: got sample=%0d voice=%0d edge=%0d, want %0d/%0d/%0d", i,
                   obs_q[i].sample, obs_q[i].voice, obs_q[i].stamp, want_s[i], i + 1, exp_q[i].stamp);
        end
      end
    end
    idle(4);
    flush();
  endtask

  task automatic test_saw_tri();
    bit ok;
    int sels[7]   = '{2, 2, 2, 3, 3, 3, 3};
    int phs[7]    = '{0, 512, 1023, 0, 511, 512, 1023};
    int want_s[7] = '{-32768, 0, 32704, -32768, 32640, 32640, -32768};
    flush();
    for (int i = 0; i < 7; i++) cyc(1'b1, 3'(sels[i]), phs[i], 0, 20 + i, 1'b1);
    wait_out(7, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL saw_tri_timeout: got %0d outputs, want 7", obs_q.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        checks++;
        if (obs_q[i].sample !== want_s[i] || obs_q[i].voice !== 20 + i) begin
          errors++;
          $display("FAIL saw_tri_%0d: got sample=%0d voice=%0d, want %0d/%0d", i,
                   obs_q[i].sample, obs_q[i].voice, want_s[i], 20 + i);
        end
      end
    end
    idle(4);
    flush();
  endtask

  task automatic test_square();
    bit ok;
    int phs[4]    = '{255, 256, 0, 1023};
    int pws[4]    = '{256, 256, 0, 1023};
    int want_s[4] = '{32767, -32767, -32767, -32767};
    flush();
    for (int i = 0; i < 4; i++) cyc(1'b1, 3'd1, phs[i], pws[i], 40 + i, 1'b1);
    wait_out(4, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL square_timeout: got %0d outputs, want 4", obs_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (obs_q[i].sample !== want_s[i]) begin
          errors++;
          $display("FAIL square_%0d: got %0d, want %0d", i, obs_q[i].sample, want_s[i]);
        end
      end
    end
    idle(4);
    flush();
  endtask

  task automatic test_stall_noise();
    bit ok;
    logic          snap_v;
    logic [SW-1:0] snap_s;
    logic [VW-1:0] snap_i;
    logic [15:0]   st;
    flush();
    st = m_lfsr;
    cyc(1'b1, 3'd4, 0, 0, 60, 1'b1);
    cyc(1'b1, 3'd4, 0, 0, 61, 1'b1);
    cyc(1'b0, 3'd4, 0, 0, 99, 1'b1);
    cyc(1'b1, 3'd4, 0, 0, 62, 1'b1);
    snap_v = vout; snap_s = samp; snap_i = vidx;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'd4, 5, 0, 98, 1'b0);
      checks++;
      if (vout !== snap_v || samp !== snap_s || vidx !== snap_i) begin
        errors++;
        $display("FAIL stall_freeze cycle %0d: got valid=%b sample=%0d voice=%0d, want %b/%0d/%0d",
                 i, vout, samp, vidx, snap_v, snap_s, snap_i);
      end
    end
    cyc(1'b1, 3'd4, 0, 0, 63, 1'b1);
    cyc(1'b0, 3'd4, 0, 0, 97, 1'b1);
    cyc(1'b1, 3'd4, 0, 0, 64, 1'b1);
    cyc(1'b1, 3'd4, 0, 0, 65, 1'b1);
    wait_out(6, ok);
    idle(5);
    checks++;
    if (!ok || obs_q.size() != 6) begin
      errors++;
      $display("FAIL stall_count: got %0d outputs, want 6", obs_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        st = lfsr_step(st);
        checks++;
        if (obs_q[i].sample !== int'($signed(st)) || obs_q[i].voice !== 60 + i || obs_q[i].stamp !== exp_q[i].stamp) begin
          errors++;
          $display("FAIL stall_noise_%0d: got sample=%0d voice=%0d edge=%0d, want %0d/%0d/%0d", i,
                   obs_q[i].sample, obs_q[i].voice, obs_q[i].stamp, int'($signed(st)), 60 + i, exp_q[i].stamp);
        end
      end
    end
    flush();
  endtask

  task automatic test_mid_reset();
    flush();
    cyc(1'b1, 3'd0, 100, 0, 70, 1'b1);
    cyc(1'b1, 3'd4, 0, 0, 71, 1'b1);
    rst_n = 1'b0;
    cyc(1'b1, 3'd2, 300, 0, 72, 1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (vout !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_quiet cycle %0d: got valid=%b, want 0", i, vout);
      end
    end
    cyc(1'b1, 3'd2, 512, 0, 33, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (vout !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_latency %0d: got valid=%b, want 0", i, vout);
      end
      idle(1);
    end
    checks++;
    if (vout !== 1'b1 || $signed(samp) !== 0 || vidx !== 8'd33 || obs_q.size() != 1) begin
      errors++;
      $display("FAIL mid_reset_first: got valid=%b sample=%0d voice=%0d outputs=%0d, want 1/0/33/1",
               vout, $signed(samp), vidx, obs_q.size());
    end
    idle(4);
    flush();
  endtask

  task automatic test_random();
    bit ok;
    int n;
    flush();
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), int'($urandom_range(0, 1023)),
          int'($urandom_range(0, 1023)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 4) != 0));
    end
    n = exp_q.size();
    wait_out(n, ok);
    idle(4);
    checks++;
    if (!ok || obs_q.size() != n) begin
      errors++;
      $display("FAIL random_count: got %0d outputs, want %0d", obs_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (obs_q[i].sample !== exp_q[i].sample || obs_q[i].voice !== exp_q[i].voice || obs_q[i].stamp !== exp_q[i].stamp) begin
          errors++;
          $display("FAIL random_%0d: got sample=%0d voice=%0d edge=%0d, want %0d/%0d/%0d", i,
                   obs_q[i].sample, obs_q[i].voice, obs_q[i].stamp, exp_q[i].sample, exp_q[i].voice, exp_q[i].stamp);
        end
      end
    end
    flush();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sine();
    test_saw_tri();
    test_square();
    test_stall_noise();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
